// File: rtl/firebird7_in_gate1_tessent_tdr_w19_pkg.sv
// Shared constants for the width-19 IJTAG test data register feeding the input-gate mux.
package firebird7_in_gate1_tessent_tdr_w19_pkg;

  localparam int   TDR_WIDTH   = 19;
  // The select bit sits just above the data field.
  localparam int   TDR_SEL_IDX = TDR_WIDTH;
  localparam logic TDR_RST_BIT = 1'b0;
  localparam logic [TDR_WIDTH:0] TDR_RST_VAL = {(TDR_WIDTH+1){TDR_RST_BIT}};

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w19.sv
// IJTAG TDR: shift register SR plus update register UR driving the input-gate mux select/data.
// Optional FIREBIRD7_TDR_FUNC_CAPTURE_EN makes capture sample functional_data_in instead of UR.
module firebird7_in_gate1_tessent_tdr_w19
  import firebird7_in_gate1_tessent_tdr_w19_pkg::*;
#(
  parameter int WIDTH = TDR_WIDTH
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select
);

  localparam int SEL = WIDTH;
  localparam logic [WIDTH:0] RST_VAL = {(WIDTH+1){TDR_RST_BIT}};

  logic [WIDTH:0] sr_q, sr_d;
  logic [WIDTH:0] ur_q, ur_d;
  logic [WIDTH:0] cap_val;

`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
  assign cap_val = {ur_q[SEL], functional_data_in};
`else
  // Read-back of UR; the functional bus is only aliased so it is visibly unused.
  logic [WIDTH-1:0] unused_func_data;
  assign unused_func_data = functional_data_in;
  assign cap_val          = ur_q;
`endif

  always_comb begin
    sr_d = sr_q;
    ur_d = ur_q;
    if (ijtag_sel) begin
      // Capture has priority over shift; update always sees the pre-edge SR.
      if (ijtag_ce)      sr_d = cap_val;
      else if (ijtag_se) sr_d = {ijtag_si, sr_q[WIDTH:1]};
      if (ijtag_ue)      ur_d = sr_q;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr_q <= RST_VAL;
      ur_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
      ur_q <= ur_d;
    end
  end

  assign ijtag_so       = sr_q[0];
  assign ijtag_select   = ur_q[SEL];
  assign ijtag_data_out = ur_q[WIDTH-1:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv
// Bench for the IJTAG TDR: bit-queue scan-chain model checked every cycle plus directed literal checks.
module tb_firebird7_in_gate1_tessent_tdr_w19;
  import firebird7_in_gate1_tessent_tdr_w19_pkg::*;

  localparam int W = TDR_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic         so;
  logic [W-1:0] func = '0;
  logic [W-1:0] dout;
  logic         osel;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  firebird7_in_gate1_tessent_tdr_w19 #(.WIDTH(W)) dut (
    .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so),
    .functional_data_in(func), .ijtag_data_out(dout), .ijtag_select(osel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan chain as a queue of bits, element 0 is the bit presented on so.
  bit           mq[$];
  logic [W:0]   mur;

  function automatic logic [W:0] chain_value();
    logic [W:0] v;
    for (int i = 0; i <= W; i++) v[i] = mq[i];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [W:0] pre, cap;
    if (rst) begin
      mq.delete();
      for (int i = 0; i <= W; i++) mq.push_back(1'b0);
      mur = '0;
    end else if (sel && mq.size() == W + 1) begin
      pre = chain_value();
`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
      cap = {mur[W], func};
`else
      cap = mur;
`endif
      if (ce) begin
        for (int i = 0; i <= W; i++) mq[i] = cap[i];
      end else if (se) begin
        void'(mq.pop_front());
        mq.push_back(si);
      end
      if (ue) mur = pre;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model_so",     {{W{1'b0}}, so},   {{W{1'b0}}, mq[0]});
      check("model_select", {{W{1'b0}}, osel}, {{W{1'b0}}, mur[W]});
      check("model_data",   {1'b0, dout},      {1'b0, mur[W-1:0]});
    end
  end

  task automatic cyc(input logic s, input logic c, input logic e, input logic u, input logic i);
    sel = s; ce = c; se = e; ue = u; si = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic shift_out(output logic [W:0] got);
    for (int i = 0; i <= W; i++) begin
      got[i] = so;
      cyc(1, 0, 1, 0, 1'b0);
    end
  endtask

  initial begin
    logic [W:0] vec, got, expv, outs;
    logic       so0;

    do_reset();
    check_en = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("reset_idle", {osel, dout}, '0);
    check("reset_so", {{W{1'b0}}, so}, '0);

    // Load {1, 5A5A5}; outputs must stay at reset values while shifting.
    vec = {1'b1, 19'h5A5A5};
    for (int i = 0; i <= W; i++) begin
      cyc(1, 0, 1, 0, vec[i]);
      check("hold_during_shift", {osel, dout}, '0);
    end
    cyc(1, 0, 0, 1, 0);
    check("update_value", {osel, dout}, 20'hDA5A5);

    // Capture then shift out.
    func = 19'h7FFFF;
    cyc(1, 1, 0, 0, 0);
    shift_out(got);
`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
    expv = 20'hFFFFF;
`else
    expv = 20'hDA5A5;
`endif
    check("capture_shift_out", got, expv);
    check("ur_kept_after_capture", {osel, dout}, 20'hDA5A5);

    // SR is zero now; ce+se with si=1 must capture and not shift.
    func = 19'h12345;
    cyc(1, 1, 1, 0, 1);
`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
    expv = {1'b1, 19'h12345};
`else
    expv = 20'hDA5A5;
`endif
    check("ce_se_so", {{W{1'b0}}, so}, {{W{1'b0}}, expv[0]});
    shift_out(got);
    check("ce_se_capture_wins", got, expv);

    // Reset partway through a shift, then a clean all-ones load.
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 1);
    rst = 1'b1;
    cyc(1, 1, 1, 1, 1);
    rst = 1'b0;
    check("mid_shift_reset_out", {osel, dout}, '0);
    check("mid_shift_reset_so", {{W{1'b0}}, so}, '0);
    for (int i = 0; i <= W; i++) cyc(1, 0, 1, 0, 1);
    check("no_update_no_change", {osel, dout}, '0);
    cyc(1, 0, 0, 1, 0);
    check("ones_after_reset", {osel, dout}, 20'hFFFFF);

    // Load a distinctive SR, then deselect with control toggling.
    vec = 20'h3C0F1;
    for (int i = 0; i <= W; i++) cyc(1, 0, 1, 0, vec[i]);
    outs = {osel, dout};
    so0  = so;
    for (int i = 0; i < 50; i++) begin
      func = W'($urandom);
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check("desel_outputs", {osel, dout}, outs);
      check("desel_so", {{W{1'b0}}, so}, {{W{1'b0}}, so0});
    end
    shift_out(got);
    check("desel_sr_intact", got, 20'h3C0F1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      func = W'($urandom);
      rst  = ($urandom_range(0, 39) == 0);
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
          1'($urandom), ($urandom_range(0, 6) == 0), 1'($urandom));
    end
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
